// File: rtl/otbn_pq_pkg.sv
// Shared types and constants for the OTBN post-quantum datapath:
// butterfly ALU opcodes and the NTT loop sequencer state encoding.
package otbn_pq_pkg;

  localparam int NttLogNMax = 8;

  // Encoding 0 is deliberately not a legal op so an idle/reset bus is inert.
  typedef enum logic [1:0] {
    AluOpPqNone        = 2'd0,
    AluOpPqButterflyCT = 2'd1,
    AluOpPqButterflyGS = 2'd2,
    AluOpPqScale       = 2'd3
  } alu_op_pq_e;

  typedef enum logic [1:0] {
    NttIdle  = 2'd0,
    NttRun   = 2'd1,
    NttScale = 2'd2,
    NttDone  = 2'd3
  } ntt_seq_state_e;

  function automatic logic ntt_log_n_legal(input logic [3:0] log_n,
                                           input logic [3:0] log_n_max);
    return (log_n != 4'd0) && (log_n <= log_n_max);
  endfunction

endpackage

// File: rtl/otbn_pq_ntt_addr_gen.sv
// Combinational butterfly address generator: maps (stage, group, inner) to
// coefficient indices and twiddle index for CT (forward) or GS (inverse).
module otbn_pq_ntt_addr_gen #(
  parameter  int LogNMax = 8,
  localparam int StageW  = $clog2(LogNMax + 1)
) (
  input  logic [StageW-1:0]  k,
  input  logic [LogNMax-1:0] g,
  input  logic [LogNMax-1:0] j,
  input  logic [3:0]         log_n,
  input  logic               inverse,
  output logic [LogNMax-1:0] half,
  output logic [LogNMax-1:0] grp_cnt,
  output logic [LogNMax-1:0] idx0,
  output logic [LogNMax-1:0] idx1,
  output logic [LogNMax-1:0] tw_idx
);

  // One extra bit so N itself is representable before the per-stage shift.
  logic [LogNMax:0] n_w, half_w, grp_w, base_w, idx0_w;

  assign n_w    = (LogNMax + 1)'(1) << log_n;
  assign half_w = inverse ? ((LogNMax + 1)'(1) << k) : (n_w >> (k + 1'b1));
  assign grp_w  = inverse ? (n_w >> (k + 1'b1)) : ((LogNMax + 1)'(1) << k);
  assign base_w = ({1'b0, g} * half_w) << 1;
  assign idx0_w = base_w + {1'b0, j};

  assign half    = half_w[LogNMax-1:0];
  assign grp_cnt = grp_w[LogNMax-1:0];
  assign idx0    = idx0_w[LogNMax-1:0];
  assign idx1    = LogNMax'(idx0_w + half_w);
  assign tw_idx  = LogNMax'(grp_w + {1'b0, g});

endmodule

// File: rtl/otbn_pq_ntt_seq.sv
// NTT butterfly loop sequencer: one start issues every CT/GS step of an
// in-place transform. OTBN_PQ_NTT_SCALE_EN appends N scale steps to inverse runs.
module otbn_pq_ntt_seq
  import otbn_pq_pkg::*;
#(
  parameter  int LogNMax = NttLogNMax,
  localparam int StageW  = $clog2(LogNMax + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [3:0]         log_n_i,
  input  logic               inverse_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               step_valid_o,
  input  logic               step_ready_i,
  output alu_op_pq_e         step_op_o,
  output logic [LogNMax-1:0] step_idx0_o,
  output logic [LogNMax-1:0] step_idx1_o,
  output logic [LogNMax-1:0] step_tw_idx_o,
  output logic [StageW-1:0]  step_stage_o
);

  ntt_seq_state_e      state_q, state_d;
  logic [StageW-1:0]   k_q, k_d;
  logic [LogNMax-1:0]  g_q, g_d, j_q, j_d;
  logic [3:0]          log_n_q, log_n_d;
  logic                inv_q, inv_d;
  // half / group count of the step currently presented, for wrap detection
  logic [LogNMax-1:0]  half_q, half_d, grps_q, grps_d;

  logic                busy_d, done_d, err_d, valid_d;
  alu_op_pq_e          op_d;
  logic [LogNMax-1:0]  idx0_d, idx1_d, tw_d;
  logic [StageW-1:0]   stage_d;

  logic [LogNMax-1:0]  a_half, a_grps, a_idx0, a_idx1, a_tw;
  logic                hs, last_j, last_g, last_k;

  assign hs     = step_valid_o & step_ready_i;
  assign last_j = (j_q == half_q - 1'b1);
  assign last_g = (g_q == grps_q - 1'b1);
  assign last_k = (k_q == StageW'(log_n_q - 4'd1));

  // Payload is computed from the next counter values so it can be registered.
  otbn_pq_ntt_addr_gen #(.LogNMax(LogNMax)) u_addr_gen (
    .k       (k_d),
    .g       (g_d),
    .j       (j_d),
    .log_n   (log_n_d),
    .inverse (inv_d),
    .half    (a_half),
    .grp_cnt (a_grps),
    .idx0    (a_idx0),
    .idx1    (a_idx1),
    .tw_idx  (a_tw)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= NttIdle;
      k_q           <= '0;
      g_q           <= '0;
      j_q           <= '0;
      log_n_q       <= '0;
      inv_q         <= 1'b0;
      half_q        <= '0;
      grps_q        <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      step_valid_o  <= 1'b0;
      step_op_o     <= AluOpPqNone;
      step_idx0_o   <= '0;
      step_idx1_o   <= '0;
      step_tw_idx_o <= '0;
      step_stage_o  <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      g_q           <= g_d;
      j_q           <= j_d;
      log_n_q       <= log_n_d;
      inv_q         <= inv_d;
      half_q        <= half_d;
      grps_q        <= grps_d;
      busy_o        <= busy_d;
      done_o        <= done_d;
      err_o         <= err_d;
      step_valid_o  <= valid_d;
      step_op_o     <= op_d;
      step_idx0_o   <= idx0_d;
      step_idx1_o   <= idx1_d;
      step_tw_idx_o <= tw_d;
      step_stage_o  <= stage_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    g_d     = g_q;
    j_d     = j_q;
    log_n_d = log_n_q;
    inv_d   = inv_q;
    err_d   = 1'b0;
    unique case (state_q)
      NttIdle: begin
        if (start_i) begin
          if (ntt_log_n_legal(log_n_i, 4'(LogNMax))) begin
            state_d = NttRun;
            k_d     = '0;
            g_d     = '0;
            j_d     = '0;
            log_n_d = log_n_i;
            inv_d   = inverse_i;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      NttRun: begin
        if (abort_i) begin
          state_d = NttIdle;
          k_d     = '0;
          g_d     = '0;
          j_d     = '0;
        end else if (hs) begin
          if (!last_j) begin
            j_d = j_q + 1'b1;
          end else begin
            j_d = '0;
            if (!last_g) begin
              g_d = g_q + 1'b1;
            end else begin
              g_d = '0;
              if (!last_k) begin
                k_d = k_q + 1'b1;
              end else begin
                k_d = '0;
`ifdef OTBN_PQ_NTT_SCALE_EN
                state_d = inv_q ? NttScale : NttDone;
`else
                state_d = NttDone;
`endif
              end
            end
          end
        end
      end
`ifdef OTBN_PQ_NTT_SCALE_EN
      NttScale: begin
        // j doubles as the coefficient index i while scaling
        if (abort_i) begin
          state_d = NttIdle;
          j_d     = '0;
        end else if (hs) begin
          if (j_q == LogNMax'(((LogNMax + 1)'(1) << log_n_q) - 1'b1)) begin
            state_d = NttDone;
            j_d     = '0;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
`endif
      NttDone: state_d = NttIdle;
      default: state_d = NttIdle;
    endcase
  end

  always_comb begin
    busy_d  = (state_d == NttRun) || (state_d == NttScale);
    valid_d = busy_d;
    done_d  = (state_d == NttDone);
    op_d    = AluOpPqNone;
    idx0_d  = '0;
    idx1_d  = '0;
    tw_d    = '0;
    stage_d = '0;
    half_d  = '0;
    grps_d  = '0;
    if (state_d == NttRun) begin
      op_d    = inv_d ? AluOpPqButterflyGS : AluOpPqButterflyCT;
      idx0_d  = a_idx0;
      idx1_d  = a_idx1;
      tw_d    = a_tw;
      stage_d = k_d;
      half_d  = a_half;
      grps_d  = a_grps;
    end else if (state_d == NttScale) begin
      op_d   = AluOpPqScale;
      idx0_d = j_d;
    end
  end

endmodule

// File: tb/tb_otbn_pq_ntt_seq.sv
// Directed self-checking bench for otbn_pq_ntt_seq; expectations follow
// OTBN_PQ_NTT_SCALE_EN when the bench is built with it.
module tb_otbn_pq_ntt_seq;
  import otbn_pq_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, inverse, abort, ready;
  logic [3:0] log_n;
  logic       busy, done, err, valid;
  alu_op_pq_e op;
  logic [7:0] idx0, idx1, tw;
  logic [3:0] stage;
  int checks = 0;
  int errors = 0;

  otbn_pq_ntt_seq dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .log_n_i(log_n),
    .inverse_i(inverse), .abort_i(abort), .busy_o(busy), .done_o(done),
    .err_o(err), .step_valid_o(valid), .step_ready_i(ready),
    .step_op_o(op), .step_idx0_o(idx0), .step_idx1_o(idx1),
    .step_tw_idx_o(tw), .step_stage_o(stage)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; log_n = 4'd0; inverse = 1'b0; abort = 1'b0; ready = 1'b0;
    tick; tick;
    checks++;
    if ({busy, done, err, valid} !== 4'b0 || op !== AluOpPqNone || idx0 !== 8'd0 ||
        idx1 !== 8'd0 || tw !== 8'd0 || stage !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got b=%b d=%b e=%b v=%b op=%0d (%0d,%0d,%0d) st=%0d want all 0",
               busy, done, err, valid, op, idx0, idx1, tw, stage);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_fwd2;
    logic [7:0] e0 [4] = '{8'd0, 8'd1, 8'd0, 8'd2};
    logic [7:0] e1 [4] = '{8'd2, 8'd3, 8'd1, 8'd3};
    logic [7:0] et [4] = '{8'd1, 8'd1, 8'd2, 8'd3};
    logic [3:0] es [4] = '{4'd0, 4'd0, 4'd1, 4'd1};
    start = 1'b1; log_n = 4'd2; inverse = 1'b0; ready = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || op !== AluOpPqButterflyCT ||
          idx0 !== e0[i] || idx1 !== e1[i] || tw !== et[i] || stage !== es[i]) begin
        errors++;
        $display("FAIL fwd2_step%0d: got v=%b b=%b op=%0d (%0d,%0d,%0d) st=%0d want CT (%0d,%0d,%0d) st=%0d",
                 i, valid, busy, op, idx0, idx1, tw, stage, e0[i], e1[i], et[i], es[i]);
      end
      tick;
    end
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fwd2_done_c5: got d=%b v=%b b=%b want d=1 v=0 b=0", done, valid, busy);
    end
    tick;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL fwd2_done_pulse: got d=%b want 0", done);
    end
  endtask

  task automatic test_inv2;
`ifdef OTBN_PQ_NTT_SCALE_EN
    localparam int S = 8;
`else
    localparam int S = 4;
`endif
    alu_op_pq_e eo [8] = '{AluOpPqButterflyGS, AluOpPqButterflyGS, AluOpPqButterflyGS,
                           AluOpPqButterflyGS, AluOpPqScale, AluOpPqScale, AluOpPqScale, AluOpPqScale};
    logic [7:0] e0 [8] = '{8'd0, 8'd2, 8'd0, 8'd1, 8'd0, 8'd1, 8'd2, 8'd3};
    logic [7:0] e1 [8] = '{8'd1, 8'd3, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] et [8] = '{8'd2, 8'd3, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    start = 1'b1; log_n = 4'd2; inverse = 1'b1; ready = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < S; i++) begin
      checks++;
      if (valid !== 1'b1 || op !== eo[i] || idx0 !== e0[i] || idx1 !== e1[i] || tw !== et[i]) begin
        errors++;
        $display("FAIL inv2_step%0d: got v=%b op=%0d (%0d,%0d,%0d) want op=%0d (%0d,%0d,%0d)",
                 i, valid, op, idx0, idx1, tw, eo[i], e0[i], e1[i], et[i]);
      end
      tick;
    end
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL inv2_done_c%0d: got d=%b v=%b want d=1 v=0", S + 1, done, valid);
    end
    tick;
  endtask

  task automatic test_err;
    logic [3:0] bad [2] = '{4'd0, 4'd9};
    for (int i = 0; i < 2; i++) begin
      start = 1'b1; log_n = bad[i]; inverse = 1'b0; ready = 1'b1;
      tick;
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL err_log_n%0d: got e=%b b=%b v=%b want e=1 b=0 v=0", bad[i], err, busy, valid);
      end
      tick;
      checks++;
      if (err !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse%0d: got e=%b v=%b b=%b want 0 0 0", bad[i], err, valid, busy);
      end
    end
  endtask

  task automatic test_abort;
    start = 1'b1; log_n = 4'd4; inverse = 1'b0; ready = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    checks++;
    if (valid !== 1'b1 || idx0 !== 8'd2 || idx1 !== 8'd10 || tw !== 8'd1) begin
      errors++;
      $display("FAIL abort_step3: got v=%b (%0d,%0d,%0d) want (2,10,1)", valid, idx0, idx1, tw);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got v=%b b=%b d=%b want 0 0 0", valid, busy, done);
    end
    tick;
    checks++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got d=%b v=%b want 0 0", done, valid);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (valid !== 1'b1 || op !== AluOpPqButterflyCT || idx0 !== 8'd0 || idx1 !== 8'd8 ||
        tw !== 8'd1 || stage !== 4'd0) begin
      errors++;
      $display("FAIL abort_restart: got v=%b op=%0d (%0d,%0d,%0d) want CT (0,8,1)", valid, op, idx0, idx1, tw);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    tick;
  endtask

  task automatic test_start_ignored;
    start = 1'b1; log_n = 4'd2; inverse = 1'b0; ready = 1'b1;
    tick;
    log_n = 4'd3; inverse = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_done: got d=%b v=%b want d=1 v=0", done, valid);
    end
    tick;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL done_start_ignored: got b=%b v=%b want 0 0", busy, valid);
    end
    tick;
  endtask

  task automatic test_fwd8_random;
    logic [7:0] m0 [$], m1 [$], mt [$];
    logic [7:0] s0, s1, st;
    logic       stalled = 1'b0;
    int         n_hs = 0, tw_n = 1, cyc = 0;
    for (int len = 128; len >= 1; len = len / 2)
      for (int base = 0; base < 256; base += 2 * len) begin
        for (int jj = base; jj < base + len; jj++) begin
          m0.push_back(8'(jj)); m1.push_back(8'(jj + len)); mt.push_back(8'(tw_n));
        end
        tw_n++;
      end
    start = 1'b1; log_n = 4'd8; inverse = 1'b0; ready = 1'b0;
    tick;
    start = 1'b0;
    while (n_hs < 1024 && cyc < 6000) begin
      if (stalled) begin
        checks++;
        if (valid !== 1'b1 || idx0 !== s0 || idx1 !== s1 || tw !== st) begin
          errors++;
          $display("FAIL fwd8_stall_c%0d: got v=%b (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                   cyc, valid, idx0, idx1, tw, s0, s1, st);
        end
      end
      ready = ($urandom_range(0, 3) != 0);
      stalled = 1'b0;
      if (valid === 1'b1 && ready) begin
        checks++;
        if (op !== AluOpPqButterflyCT || idx0 !== m0[n_hs] || idx1 !== m1[n_hs] || tw !== mt[n_hs]) begin
          errors++;
          $display("FAIL fwd8_step%0d: got op=%0d (%0d,%0d,%0d) want CT (%0d,%0d,%0d)",
                   n_hs, op, idx0, idx1, tw, m0[n_hs], m1[n_hs], mt[n_hs]);
        end
        n_hs++;
      end else if (valid === 1'b1) begin
        stalled = 1'b1; s0 = idx0; s1 = idx1; st = tw;
      end
      tick;
      cyc++;
    end
    ready = 1'b1;
    checks++;
    if (n_hs != 1024 || done !== 1'b1) begin
      errors++;
      $display("FAIL fwd8_complete: got %0d steps d=%b want 1024 steps d=1", n_hs, done);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    start = 1'b1; log_n = 4'd2; inverse = 1'b1; ready = 1'b1;
    tick;
    start = 1'b0;
`ifdef OTBN_PQ_NTT_SCALE_EN
    for (int i = 0; i < 5; i++) tick;
`else
    tick; tick;
`endif
    checks++;
    if (valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got v=%b b=%b want 1 1", valid, busy);
    end
    rst = 1'b1;
    tick;
    checks++;
    if ({busy, done, err, valid} !== 4'b0 || op !== AluOpPqNone || idx0 !== 8'd0 ||
        idx1 !== 8'd0 || tw !== 8'd0 || stage !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid: got b=%b d=%b e=%b v=%b op=%0d (%0d,%0d,%0d) want all 0",
               busy, done, err, valid, op, idx0, idx1, tw);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle: got v=%b d=%b want 0 0", valid, done);
    end
  endtask

  initial begin
    test_reset;
    test_fwd2;
    test_inv2;
    test_err;
    test_abort;
    test_start_ignored;
    test_fwd8_random;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/otbn_pq_ntt_seq.md
# otbn_pq_ntt_seq

Hardware loop sequencer for the PQ butterfly ALU. On a single start command it generates the full sequence of butterfly steps for an in-place NTT:
- forward transforms use Cooley-Tukey butterflies;
- inverse transforms use Gentleman-Sande butterflies;
- each step carries the operation, both coefficient indices and the twiddle-table index.

It replaces the software m/j2/j/idx0/idx1 loop maintenance and sits between the OTBN controller and the PQ ALU/WDR address logic.

## Interface
- LogNMax, default 8: log2 of the largest supported transform size (N=256).
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  start request; sampled only in IDLE.
- log_n_i  in  4  log2(N) for this run; legal range 1..LogNMax.
- inverse_i  in  1  0 = forward (CT), 1 = inverse (GS).
- abort_i  in  1  terminates a run.
- busy_o  out  1  run in progress (RUN or SCALE).
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse on illegal log_n_i at start.
- step_valid_o  out  1  step payload valid.
- step_ready_i  in  1  ALU accepts the step.
- step_op_o  out  alu_op_pq_e  AluOpPqButterflyCT, AluOpPqButterflyGS or AluOpPqScale.
- step_idx0_o  out  LogNMax  first coefficient index.
- step_idx1_o  out  LogNMax  second coefficient index (0 for scale steps).
- step_tw_idx_o  out  LogNMax  twiddle-table index.
- step_stage_o  out  $clog2(LogNMax+1)  current stage number.

## Operation
- States: IDLE, RUN, SCALE, DONE.
- Counters: stage k, group g, inner j. Per run: N = 1<<log_n.
- Per-stage parameters:
  - forward: half = N>>(k+1), G = 1<<k;
  - inverse: half = 1<<k, G = N>>(k+1).
- Per-step outputs: idx0 = g·2·half + j; idx1 = idx0 + half; tw_idx = G + g.
- Counter advance on each handshake (step_valid_o & step_ready_i):
  - j = half−1 wraps j to 0 and increments g;
  - g = G−1 as well wraps g to 0 and increments k;
  - the last step of stage log_n−1 leaves RUN.
- Each run issues log_n·N/2 butterfly steps.
- IDLE→RUN: on start_i with a legal log_n_i. Counters clear; log_n_i and inverse_i are latched.
- IDLE, illegal log_n_i (0 or >LogNMax): err_o pulses next cycle; state stays IDLE.
- RUN exit: after the last butterfly handshake, go to SCALE if inverse and the scale feature is present, else DONE.
- SCALE: issues N steps with op AluOpPqScale, idx0 = i (0..N−1), idx1 = 0, tw_idx = 0. After the last handshake, go to DONE.
- DONE: done_o = 1 for exactly one cycle, then IDLE.
- start_i outside IDLE is ignored.
- abort_i in RUN or SCALE: go to IDLE next cycle. No done_o, counters cleared, step_valid_o low next cycle. abort_i has priority over a simultaneous handshake.
- Reset at any point, including mid-run: state IDLE. All outputs 0, including step_op_o (encoded value 0, not a legal op) and the counters.

## Timing
- All outputs are registered.
- Start is sampled at edge 0; step_valid_o rises at cycle 1.
- Throughput is one step per cycle while step_ready_i is held high.
- Handshake rule: step_valid_o stays asserted and every step_* payload stays stable until step_ready_i. step_valid_o never drops without a handshake except on abort or reset.
- With ready constantly high and S total steps:
  - handshakes occur in cycles 1..S;
  - busy_o is high in cycles 1..S;
  - done_o is high in cycle S+1;
  - a new start is accepted at cycle S+2.
- Backpressure (ready low) extends the run cycle-for-cycle.
- Stage and group wrap, and the RUN→SCALE transition, insert no bubble cycles.

## Configuration
- Macro: OTBN_PQ_NTT_SCALE_EN.
- Defined: the SCALE state exists and inverse runs append N AluOpPqScale steps (the multiply by N⁻¹ in Montgomery form).
- Undefined: the SCALE state is not compiled; inverse runs go from RUN to DONE and AluOpPqScale is never emitted.
- Forward runs are identical either way.

## Structure
- otbn_pq_pkg gains:
  - the state enum ntt_seq_state_e {NttIdle, NttRun, NttScale, NttDone};
  - the constant NttLogNMax = 8.
- Sub-module otbn_pq_ntt_addr_gen: purely combinational; computes half, G, idx0, idx1 and tw_idx from (k, g, j, log_n, inverse).
- The top holds the FSM, the counters and the output registers.

## Test plan
- Forward, log_n=2, ready=1 -> exactly four CT steps (idx0, idx1, tw): (0,2,1), (1,3,1), (0,1,2), (2,3,3); done_o at cycle 5.
- Inverse, log_n=2, with OTBN_PQ_NTT_SCALE_EN:
  - GS steps (0,1,2), (2,3,3), (0,2,1), (1,3,1);
  - then scale steps idx0 = 0,1,2,3;
  - done_o at cycle 9.
  - Without the macro, done_o at cycle 5.
- Forward, log_n=8, random ready -> 1024 steps; each index pair is exactly once per stage; payload is stable during every stall; tw_idx spans 1..255.
- log_n_i = 0 and log_n_i = 9 at start -> err_o pulse; busy_o stays 0; no valid.
- abort_i at step 3 of a log_n=4 run, asserted together with ready -> IDLE next cycle; no done_o; a fresh start two cycles later begins at (0,8,1).
- rst_i mid-SCALE -> all outputs 0 next cycle; start_i is ignored while busy and in DONE.
